apb_master_arbiter: RTL and testbench

- Round-robin arbiter plus APB master sequencer that shares one APB master port among NUM_REQ requesters.
- Accepts simple valid/ready transfer requests and drives the APB SETUP/ACCESS phases.
- Honours pready wait states and returns read data and the error flag to the granted requester.
- Sits between internal bus clients and the APB peripheral fabric, which includes slaves that insert wait states.

---
 rtl/apb_master_arbiter.sv | 132 +++++++++++++
 tb/tb_apb_master_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin arbiter sharing one APB master port among NUM_REQ requesters.
// Define APB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYCLES with an error response.
module apb_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        pclk,
  input  logic                        preset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        psel,
  output logic                        penable,
  output logic                        pwrite,
  output logic [ADDR_W-1:0]           paddr,
  output logic [DATA_W-1:0]           pwdata,
  input  logic [DATA_W-1:0]           prdata,
  input  logic                        pready,
  input  logic                        pslverr
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("apb_master_arbiter: unsupported parameter value");
  end
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_d;
  logic [IW-1:0] rr, rr_d, gnt, gnt_d, pick;
  logic [IW:0] sum;
  logic found, done, tmo;
  logic [NUM_REQ-1:0] req_ready_d, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d, pwdata_d;
  logic [ADDR_W-1:0] paddr_d;
  logic rsp_err_d, psel_d, penable_d, pwrite_d;
  // first valid requester at or after rr, wrapping
  always_comb begin
    found = 1'b0;
    pick = '0;
    sum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr} + (IW+1)'(k);
      if (sum >= NR) sum = sum - NR;
      if (!found && req_valid[sum[IW-1:0]]) begin
        found = 1'b1;
        pick = sum[IW-1:0];
      end
    end
  end
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge pclk or posedge preset)
    if (preset) cnt <= '0;
    else if (state != ACCESS) cnt <= '0;
    else if (!pready) cnt <= cnt + 1'b1;
  // cnt counts completed wait cycles; a ready on the last cycle still completes normally
  assign tmo = !pready && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  assign done = state == ACCESS && (pready || tmo);
  always_comb begin
    state_d = state;
    rr_d = rr;
    gnt_d = gnt;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d = rsp_err;
    psel_d = psel;
    penable_d = penable;
    pwrite_d = pwrite;
    paddr_d = paddr;
    pwdata_d = pwdata;
    if (state == IDLE && found) begin
      state_d = SETUP;
      gnt_d = pick;
      req_ready_d[pick] = 1'b1;
      psel_d = 1'b1;
      penable_d = 1'b0;
      pwrite_d = req_write[pick];
      paddr_d = req_addr[pick*ADDR_W +: ADDR_W];
      pwdata_d = req_wdata[pick*DATA_W +: DATA_W];
    end else if (state == SETUP) begin
      state_d = ACCESS;
      penable_d = 1'b1;
    end else if (done) begin
      state_d = IDLE;
      psel_d = 1'b0;
      penable_d = 1'b0;
      rr_d = gnt == IW'(NUM_REQ - 1) ? '0 : gnt + 1'b1;
      rsp_valid_d[gnt] = 1'b1;
      rsp_rdata_d = (pready && !pwrite) ? prdata : '0;
      rsp_err_d = pready ? pslverr : 1'b1;
    end
  end
  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      state <= IDLE;
      rr <= '0;
      gnt <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      psel <= 1'b0;
      penable <= 1'b0;
      pwrite <= 1'b0;
      paddr <= '0;
      pwdata <= '0;
    end else begin
      state <= state_d;
      rr <= rr_d;
      gnt <= gnt_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err <= rsp_err_d;
      psel <= psel_d;
      penable <= penable_d;
      pwrite <= pwrite_d;
      paddr <= paddr_d;
      pwdata <= pwdata_d;
    end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: randomized self-checking bench; round-robin and response model kept at transfer level.
module tb_apb_master_arbiter;
  localparam int N = 3, AW = 32, DW = 32;
  logic pclk = 1'b0, preset = 1'b1;
  logic [N-1:0] req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, pwdata, prdata;
  logic [AW-1:0] paddr;
  logic rsp_err, psel, penable, pwrite, pready, pslverr;
  int total = 0, bad = 0, m_rr = 0;
  int o_gi, o_acc, o_nrsp, o_ridx, o_lat;
  logic o_ok, o_gw, o_rerr;
  logic [AW-1:0] o_ga;
  logic [DW-1:0] o_gd, o_rdat;
  logic [AW-1:0] ea [N];
  logic [DW-1:0] ed [N];
  logic ew [N];

  always #5 pclk = ~pclk;

  apb_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .preset(preset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr));

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    ew[i] = w;
    ea[i] = a;
    ed[i] = d;
  endtask

  // runs one transfer with wait_n wait states and records what the APB port and responses did
  task automatic xfer(input int wait_n, input logic [DW-1:0] rd, input logic err);
    o_gi = -1; o_ok = 1'b1; o_acc = 0; o_nrsp = 0; o_ridx = -1; o_rdat = 'x; o_rerr = 1'bx; o_lat = 0;
    do begin tick(); o_lat++; end while (req_ready == '0 && o_lat < 8);
    if (req_ready == '0) return;
    for (int i = 0; i < N; i++) if (req_ready[i]) o_gi = i;
    o_ok = $onehot(req_ready) && psel && !penable && rsp_valid == '0;
    o_ga = paddr; o_gw = pwrite; o_gd = pwdata;
    req_valid[o_gi] = 1'b0;
    req_write[o_gi] = ~req_write[o_gi];
    req_addr[o_gi*AW +: AW] = $urandom;
    req_wdata[o_gi*DW +: DW] = $urandom;
    pready = 1'b0;
    tick();
    o_ok = o_ok && psel && penable && req_ready == '0 && paddr === o_ga && pwrite === o_gw && pwdata === o_gd;
    if (penable) o_acc++;
    for (int k = 0; k < wait_n; k++) begin
      pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
      tick();
      if (rsp_valid != '0) o_nrsp++;
      if (penable) o_acc++;
      o_ok = o_ok && psel && penable && paddr === o_ga && pwrite === o_gw && pwdata === o_gd;
    end
    pready = 1'b1; prdata = rd; pslverr = err;
    tick();
    if (rsp_valid != '0) begin
      o_nrsp++;
      o_ridx = -2;
      for (int i = 0; i < N; i++) if (rsp_valid == N'(1 << i)) o_ridx = i;
      o_rdat = rsp_rdata; o_rerr = rsp_err;
    end
    o_ok = o_ok && !psel && !penable;
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
  endtask

  task automatic test_reset;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0; preset = 1'b1;
    repeat (2) tick();
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata} !== '0) begin
      bad++; $display("FAIL reset_outputs: got psel=%b penable=%b req_ready=%b rsp_valid=%b paddr=%h want all zero", psel, penable, req_ready, rsp_valid, paddr);
    end
    preset = 1'b0; m_rr = 0;
    tick();
    total++;
    if (psel !== 1'b0 || req_ready !== '0) begin
      bad++; $display("FAIL idle_no_req: got psel=%b req_ready=%b want 0", psel, req_ready);
    end
  endtask

  task automatic test_single_read;
    int eg;
    set_req(0, 1'b0, 32'h40, $urandom);
    eg = rr_pick(req_valid, m_rr);
    xfer(0, 32'hDEADBEEF, 1'b0);
    req_valid = '0; m_rr = (eg + 1) % N;
    total++; if (o_gi !== eg) begin bad++; $display("FAIL single_grant: got %0d want %0d", o_gi, eg); end
    total++; if (o_ok !== 1'b1) begin bad++; $display("FAIL single_phases: got %b want 1", o_ok); end
    total++; if (o_ga !== 32'h40 || o_gw !== 1'b0) begin bad++; $display("FAIL single_addr: got %h/%b want 40/0", o_ga, o_gw); end
    total++; if (o_acc !== 1 || o_nrsp !== 1 || o_ridx !== eg) begin bad++; $display("FAIL single_rsp: got acc=%0d n=%0d idx=%0d want 1 1 %0d", o_acc, o_nrsp, o_ridx, eg); end
    total++; if (o_rdat !== 32'hDEADBEEF || o_rerr !== 1'b0) begin bad++; $display("FAIL single_data: got %h err=%b want deadbeef err=0", o_rdat, o_rerr); end
  endtask

  task automatic test_wait_states;
    int eg;
    logic [DW-1:0] rd;
    rd = $urandom;
    set_req(0, 1'b0, 32'h40, $urandom);
    eg = rr_pick(req_valid, m_rr);
    xfer(3, rd, 1'b0);
    req_valid = '0; m_rr = (eg + 1) % N;
    total++; if (o_ok !== 1'b1 || o_ga !== 32'h40) begin bad++; $display("FAIL wait_hold: got ok=%b addr=%h want 1 40", o_ok, o_ga); end
    total++; if (o_acc !== 4) begin bad++; $display("FAIL wait_access_cycles: got %0d want 4", o_acc); end
    total++; if (o_nrsp !== 1 || o_rdat !== rd || o_rerr !== 1'b0) begin bad++; $display("FAIL wait_rsp: got n=%0d data=%h err=%b want 1 %h 0", o_nrsp, o_rdat, o_rerr, rd); end
  endtask

  task automatic test_contention;
    logic [N-1:0] masks [3];
    int eg, cnt;
    masks[0] = 3'b011; masks[1] = 3'b001; masks[2] = 3'b011;
    for (int p = 0; p < 3; p++) begin
      if (masks[p][0]) set_req(0, 1'b1, 32'h10, 32'h11111111);
      if (masks[p][1]) set_req(1, 1'b1, 32'h20, 32'h22222222);
      cnt = $countones(masks[p]);
      for (int t = 0; t < cnt; t++) begin
        eg = rr_pick(req_valid, m_rr);
        xfer(int'($urandom_range(0, 2)), $urandom, 1'b0);
        m_rr = (eg + 1) % N;
        total++; if (o_gi !== eg) begin bad++; $display("FAIL contention_grant: got %0d want %0d", o_gi, eg); end
        total++;
        if (o_ga !== ea[eg] || o_gd !== ed[eg] || o_gw !== 1'b1 || o_lat !== 1) begin
          bad++; $display("FAIL contention_payload: got %h/%h/%b lat=%0d want %h/%h/1 lat=1", o_ga, o_gd, o_gw, o_lat, ea[eg], ed[eg]);
        end
        total++; if (o_nrsp !== 1 || o_ridx !== eg || o_rdat !== '0) begin bad++; $display("FAIL contention_rsp: got n=%0d idx=%0d data=%h want 1 %0d 0", o_nrsp, o_ridx, o_rdat, eg); end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_slave_error;
    int eg;
    set_req(2, 1'b1, 32'h80, $urandom);
    eg = rr_pick(req_valid, m_rr);
    xfer(1, 32'hFFFF0000, 1'b1);
    req_valid = '0; m_rr = (eg + 1) % N;
    total++; if (o_gi !== eg || o_ga !== 32'h80 || o_gw !== 1'b1) begin bad++; $display("FAIL err_grant: got %0d %h %b want %0d 80 1", o_gi, o_ga, o_gw, eg); end
    total++; if (o_rerr !== 1'b1 || o_rdat !== '0 || o_nrsp !== 1) begin bad++; $display("FAIL err_rsp: got err=%b data=%h n=%0d want 1 0 1", o_rerr, o_rdat, o_nrsp); end
  endtask

  task automatic test_random;
    int eg, wn;
    logic [N-1:0] m;
    logic [DW-1:0] rd;
    logic er;
    for (int it = 0; it < 20; it++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) if (m[i]) set_req(i, 1'($urandom), $urandom, $urandom);
      eg = rr_pick(req_valid, m_rr);
      wn = int'($urandom_range(0, 6)); rd = $urandom; er = 1'($urandom);
      xfer(wn, rd, er);
      req_valid = '0; m_rr = (eg + 1) % N;
      total++; if (o_gi !== eg) begin bad++; $display("FAIL rand_grant[%0d]: got %0d want %0d mask=%b", it, o_gi, eg, m); end
      total++;
      if (o_ok !== 1'b1 || o_acc !== wn + 1 || o_ga !== ea[eg] || o_gw !== ew[eg] || (ew[eg] && o_gd !== ed[eg])) begin
        bad++; $display("FAIL rand_apb[%0d]: got ok=%b acc=%0d addr=%h w=%b want 1 %0d %h %b", it, o_ok, o_acc, o_ga, o_gw, wn + 1, ea[eg], ew[eg]);
      end
      total++;
      if (o_nrsp !== 1 || o_ridx !== eg || o_rdat !== (ew[eg] ? '0 : rd) || o_rerr !== er) begin
        bad++; $display("FAIL rand_rsp[%0d]: got n=%0d idx=%0d data=%h err=%b want 1 %0d %h %b", it, o_nrsp, o_ridx, o_rdat, o_rerr, eg, ew[eg] ? '0 : rd, er);
      end
    end
  endtask

  task automatic test_back_to_back;
    int eg;
    for (int i = 0; i < N; i++) set_req(i, 1'($urandom), $urandom, $urandom);
    for (int t = 0; t < 2 * N; t++) begin
      eg = rr_pick(req_valid, m_rr);
      xfer(int'($urandom_range(0, 1)), $urandom, 1'b0);
      m_rr = (eg + 1) % N;
      if (o_gi >= 0) set_req(o_gi, 1'($urandom), $urandom, $urandom);
      total++; if (o_gi !== eg || o_lat !== 1 || o_nrsp !== 1) begin bad++; $display("FAIL rotation[%0d]: got %0d lat=%0d n=%0d want %0d lat=1 n=1", t, o_gi, o_lat, o_nrsp, eg); end
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid;
    int t, eg, nr;
    set_req(0, 1'b0, $urandom, $urandom);
    eg = rr_pick(req_valid, m_rr);
    xfer(0, $urandom, 1'b0);
    req_valid = '0; m_rr = (eg + 1) % N;
    set_req((m_rr + 1) % N, 1'b0, 32'h44, $urandom);
    t = 0;
    do begin tick(); t++; end while (req_ready == '0 && t < 8);
    req_valid = '0; pready = 1'b0;
    repeat (2) tick();
    total++; if (psel !== 1'b1 || penable !== 1'b1) begin bad++; $display("FAIL mid_in_access: got psel=%b penable=%b want 1 1", psel, penable); end
    #3 preset = 1'b1;
    #1;
    total++; if (psel !== 1'b0 || penable !== 1'b0) begin bad++; $display("FAIL mid_async_drop: got psel=%b penable=%b want 0 0", psel, penable); end
    nr = 0;
    pready = 1'b1;
    tick(); if (rsp_valid != '0) nr++;
    preset = 1'b0; m_rr = 0;
    tick(); if (rsp_valid != '0) nr++;
    pready = 1'b0;
    tick(); if (rsp_valid != '0) nr++;
    total++; if (nr !== 0) begin bad++; $display("FAIL mid_no_rsp: got %0d responses want 0", nr); end
    set_req(N - 1, 1'b1, $urandom, $urandom);
    set_req(0, 1'b1, $urandom, $urandom);
    eg = rr_pick(req_valid, m_rr);
    xfer(0, $urandom, 1'b0);
    req_valid = '0; m_rr = (eg + 1) % N;
    total++; if (o_gi !== eg || o_nrsp !== 1) begin bad++; $display("FAIL mid_restart_grant: got %0d n=%0d want %0d n=1", o_gi, o_nrsp, eg); end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout;
    int eg, t, n;
    logic er;
    logic [DW-1:0] rd;
    rd = $urandom; er = 1'($urandom);
    set_req(m_rr, 1'b0, $urandom, $urandom);
    eg = rr_pick(req_valid, m_rr);
    xfer(15, rd, er);
    req_valid = '0; m_rr = (eg + 1) % N;
    total++; if (o_acc !== 16 || o_nrsp !== 1 || o_rdat !== rd || o_rerr !== er) begin bad++; $display("FAIL tmo_last_cycle: got acc=%0d n=%0d data=%h err=%b want 16 1 %h %b", o_acc, o_nrsp, o_rdat, o_rerr, rd, er); end
    set_req(m_rr, 1'b0, $urandom, $urandom);
    eg = rr_pick(req_valid, m_rr);
    t = 0;
    do begin tick(); t++; end while (req_ready == '0 && t < 8);
    req_valid = '0; pready = 1'b0;
    n = 0; t = 0;
    do begin
      prdata = $urandom;
      tick(); t++;
      if (rsp_valid == '0 && penable) n++;
    end while (rsp_valid == '0 && t < 40);
    m_rr = (eg + 1) % N;
    total++; if (n !== 16 || rsp_valid !== N'(1 << eg)) begin bad++; $display("FAIL tmo_cycles: got %0d cycles rsp=%b want 16 %b", n, rsp_valid, N'(1 << eg)); end
    total++; if (rsp_err !== 1'b1 || rsp_rdata !== '0 || psel !== 1'b0) begin bad++; $display("FAIL tmo_rsp: got err=%b data=%h psel=%b want 1 0 0", rsp_err, rsp_rdata, psel); end
  endtask
`endif

  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_wait_states();
    test_slave_error();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
